// File: rtl/i2c_uart_pkg.sv
// Shared definitions for the I2C/UART bridge: frame geometry, FSM states,
// default sync byte, arbiter op-codes and the frame checksum.
package i2c_uart_pkg;

    localparam int           FRAME_BYTES       = 6;
    localparam logic [2:0]   LAST_IDX          = 3'(FRAME_BYTES - 1);
    localparam logic [7:0]   DEFAULT_SYNC_BYTE = 8'hA5;

    // Low two bits of toPC_mode, shared with the arbiter.
    localparam logic [1:0]   OP_READ  = 2'b00;
    localparam logic [1:0]   OP_WRITE = 2'b01;
    localparam logic [1:0]   OP_PROBE = 2'b10;
    localparam logic [1:0]   OP_RESET = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } bridge_state_t;

    // Two's complement of the byte sum, so bytes 1..5 of a frame sum to zero mod 256.
    function automatic logic [7:0] frame_checksum(input logic [7:0]  addr,
                                                  input logic [7:0]  mode,
                                                  input logic [15:0] data);
        logic [7:0] sum;
        sum = addr + mode + data[15:8] + data[7:0];
        return 8'(-sum);
    endfunction

endpackage

// File: rtl/i2c_uart_bridge.sv
// Latches one arbiter result record and serialises it to the UART as
// SYNC, addr, mode, data_hi, data_lo, checksum; tx_complete paces the arbiter.
module i2c_uart_bridge
    import i2c_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [7:0]  toPC_address,
    input  logic [7:0]  toPC_mode,
    input  logic [15:0] toPC_data,
    output logic        tx_complete,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic        uart_tx_idle,
    output logic [7:0]  drop_count
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    bridge_state_t    state;
    logic [2:0]       idx;
    logic [7:0]       rec_addr;
    logic [7:0]       rec_mode;
    logic [15:0]      rec_data;
    logic [7:0]       rec_chk;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;

    // Masked by data_ready so the arbiter cannot pop a second record in the accept cycle.
    assign tx_complete   = (state == IDLE) && !data_ready;
    assign uart_tx_valid = (state == SEND);
    assign accept        = uart_tx_valid && uart_tx_ready;

    always_comb begin
        // NOTE: default assignment first so no path leaves uart_tx_data unassigned (no latch).
        uart_tx_data = 8'h00;
        if (state == SEND) begin
            case (idx)
                3'd0:    uart_tx_data = SYNC_BYTE;
                3'd1:    uart_tx_data = rec_addr;
                3'd2:    uart_tx_data = rec_mode;
                3'd3:    uart_tx_data = rec_data[15:8];
                3'd4:    uart_tx_data = rec_data[7:0];
                3'd5:    uart_tx_data = rec_chk;
                default: uart_tx_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; record regs are plain
        // flops (not a memory array), so clearing them in reset is cheap and deterministic.
        if (reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            rec_addr <= 8'h00;
            rec_mode <= 8'h00;
            rec_data <= 16'h0000;
            rec_chk  <= 8'h00;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_ready) begin
                        rec_addr <= toPC_address;
                        rec_mode <= toPC_mode;
                        rec_data <= toPC_data;
                        rec_chk  <= frame_checksum(toPC_address, toPC_mode, toPC_data);
                        idx      <= 3'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (uart_tx_idle) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_W'(GAP_CYCLES);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Loaded with GAP_CYCLES, so the state lasts exactly that many clocks.
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any record offered while busy (including the cycle IDLE is re-entered) is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= 8'h00;
        end else if (data_ready && (state != IDLE) && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
